// File: rtl/uart_ice40_cfg_if.sv
// Host-side word interface of uart_ice40_cfg: TX request/data and RX word/status.
// The host takes the master modport and the UART core takes the slave modport.
interface uart_ice40_cfg_if #(parameter int DATABITS = 8);
    logic                load;
    logic [DATABITS-1:0] d;
    logic                txbusy;
    logic                bytercvd;
    logic [DATABITS-1:0] q;
    logic [1:0]          rxst;
    logic                parerr;
    logic                framerr;

    modport master (output load, d, input txbusy, bytercvd, q, rxst, parerr, framerr);
    modport slave  (input load, d, output txbusy, bytercvd, q, rxst, parerr, framerr);
endinterface

// File: rtl/uart_ice40_cfg.sv
// Full-duplex UART with configurable data width, parity and stop bits.
// Bit timing comes from an external oversample enable, bitxce.
module uart_ice40_cfg #(
    parameter int DATABITS          = 8,
    parameter int PARITY            = 0,
    parameter int STOPBITS          = 1,
    parameter int SUBDIV16          = 0,
    parameter int ADJUSTSAMPLEPOINT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bitxce,
    output logic             txpin,
    input  logic             rxpin,
    uart_ice40_cfg_if.slave  host
);
    localparam int OSR       = (SUBDIV16 != 0) ? 16 : 8;
    localparam int PBIT      = (PARITY != 0) ? 1 : 0;
    localparam int NB        = DATABITS + PBIT;
    localparam int SAMP      = (ADJUSTSAMPLEPOINT != 0) ? OSR / 2 - 1 : OSR / 2;
    localparam int CW        = 6;
    localparam int BW        = 4;

    localparam logic [CW-1:0] OSR_LAST  = CW'(OSR - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOPBITS * OSR - 1);
    localparam logic [CW-1:0] SAMP_LAST = CW'(SAMP - 1);
    localparam logic [BW-1:0] DB_LAST   = BW'(DATABITS - 1);
    localparam logic [BW-1:0] NB_LAST   = BW'(NB - 1);

    function automatic logic par_bit(input logic [DATABITS-1:0] w);
        par_bit = (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT = 2'b00, RX_START = 2'b01,
                              RX_DATA = 2'b10, RX_STOP  = 2'b11} rx_state_t;

    tx_state_t           tx_st, tx_nx;
    logic [CW-1:0]       tx_cnt, tx_cnt_nx;
    logic [BW-1:0]       tx_bit, tx_bit_nx;
    logic [DATABITS-1:0] tx_sh, tx_sh_nx;
    logic                tx_par, tx_par_nx;
    logic                tx_bit_end;

    rx_state_t           rx_st, rx_nx;
    logic [CW-1:0]       rx_cnt, rx_cnt_nx;
    logic [BW-1:0]       rx_bit, rx_bit_nx;
    logic [NB-1:0]       rx_sh, rx_sh_nx;
    logic                rx_brk, rx_brk_nx;
    logic                rx_bit_end;
    logic                rcv_r, rcv_nx;
    logic [DATABITS-1:0] q_r, q_nx;
    logic                parerr_r, parerr_nx;
    logic                framerr_r, framerr_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
        end else begin
            tx_st  <= tx_nx;
            tx_cnt <= tx_cnt_nx;
            tx_bit <= tx_bit_nx;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh  <= tx_sh_nx;
        tx_par <= tx_par_nx;
    end

    always_comb begin
        tx_nx      = tx_st;
        tx_cnt_nx  = tx_cnt;
        tx_bit_nx  = tx_bit;
        tx_sh_nx   = tx_sh;
        tx_par_nx  = tx_par;
        tx_bit_end = (tx_cnt == OSR_LAST);
        case (tx_st)
            TX_IDLE: begin
                if (host.load) begin
                    tx_nx     = TX_START;
                    tx_sh_nx  = host.d;
                    tx_par_nx = par_bit(host.d);
                    tx_cnt_nx = '0;
                end
            end
            TX_START: begin
                if (bitxce) begin
                    if (tx_bit_end) begin
                        tx_nx     = TX_DATA;
                        tx_cnt_nx = '0;
                        tx_bit_nx = '0;
                    end else begin
                        tx_cnt_nx = tx_cnt + CW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (bitxce) begin
                    if (tx_bit_end) begin
                        tx_cnt_nx = '0;
                        tx_sh_nx  = tx_sh >> 1;
                        if (tx_bit == DB_LAST) tx_nx = (PBIT != 0) ? TX_PAR : TX_STOP;
                        else                   tx_bit_nx = tx_bit + BW'(1);
                    end else begin
                        tx_cnt_nx = tx_cnt + CW'(1);
                    end
                end
            end
            TX_PAR: begin
                if (bitxce) begin
                    if (tx_bit_end) begin
                        tx_nx     = TX_STOP;
                        tx_cnt_nx = '0;
                    end else begin
                        tx_cnt_nx = tx_cnt + CW'(1);
                    end
                end
            end
            TX_STOP: begin
                // All stop bits are timed as one long run of ticks.
                if (bitxce) begin
                    if (tx_cnt == STOP_LAST) begin
                        tx_nx     = TX_IDLE;
                        tx_cnt_nx = '0;
                    end else begin
                        tx_cnt_nx = tx_cnt + CW'(1);
                    end
                end
            end
            default: tx_nx = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_st)
            TX_START: txpin = 1'b0;
            TX_DATA:  txpin = tx_sh[0];
            TX_PAR:   txpin = tx_par;
            default:  txpin = 1'b1;
        endcase
    end

    assign host.txbusy = (tx_st != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st     <= RX_HUNT;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_brk    <= 1'b0;
            rcv_r     <= 1'b0;
            q_r       <= '0;
            parerr_r  <= 1'b0;
            framerr_r <= 1'b0;
        end else begin
            rx_st     <= rx_nx;
            rx_cnt    <= rx_cnt_nx;
            rx_bit    <= rx_bit_nx;
            rx_brk    <= rx_brk_nx;
            rcv_r     <= rcv_nx;
            q_r       <= q_nx;
            parerr_r  <= parerr_nx;
            framerr_r <= framerr_nx;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh <= rx_sh_nx;
    end

    // rx_cnt counts ticks since the last sample, so every sample lands OSR ticks apart.
    always_comb begin
        rx_nx      = rx_st;
        rx_cnt_nx  = rx_cnt;
        rx_bit_nx  = rx_bit;
        rx_sh_nx   = rx_sh;
        rx_brk_nx  = rx_brk;
        rcv_nx     = 1'b0;
        q_nx       = q_r;
        parerr_nx  = parerr_r;
        framerr_nx = framerr_r;
        rx_bit_end = (rx_cnt == OSR_LAST);
        case (rx_st)
            RX_HUNT: begin
                if (bitxce && !rxpin) begin
                    rx_nx     = RX_START;
                    rx_cnt_nx = '0;
                end
            end
            RX_START: begin
                if (bitxce) begin
                    if (rx_cnt == SAMP_LAST) begin
                        rx_cnt_nx = '0;
                        rx_bit_nx = '0;
                        rx_nx     = rxpin ? RX_HUNT : RX_DATA;
                    end else begin
                        rx_cnt_nx = rx_cnt + CW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (bitxce) begin
                    if (rx_bit_end) begin
                        rx_cnt_nx = '0;
                        rx_sh_nx  = {rxpin, rx_sh[NB-1:1]};
                        if (rx_bit == NB_LAST) rx_nx = RX_STOP;
                        else                   rx_bit_nx = rx_bit + BW'(1);
                    end else begin
                        rx_cnt_nx = rx_cnt + CW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (bitxce) begin
                    if (rx_brk) begin
                        if (rxpin) begin
                            rx_nx     = RX_HUNT;
                            rx_brk_nx = 1'b0;
                        end
                    end else if (rx_bit_end) begin
                        rx_cnt_nx  = '0;
                        rcv_nx     = 1'b1;
                        q_nx       = rx_sh[DATABITS-1:0];
                        parerr_nx  = (PBIT != 0) && (rx_sh[NB-1] != par_bit(rx_sh[DATABITS-1:0]));
                        framerr_nx = !rxpin;
                        if (rxpin) rx_nx = RX_HUNT;
                        else       rx_brk_nx = 1'b1;
                    end else begin
                        rx_cnt_nx = rx_cnt + CW'(1);
                    end
                end
            end
            default: rx_nx = RX_HUNT;
        endcase
    end

    assign host.bytercvd = rcv_r;
    assign host.q        = q_r;
    assign host.rxst     = rx_st;
    assign host.parerr   = parerr_r;
    assign host.framerr  = framerr_r;
endmodule

// File: tb/tb_uart_ice40_cfg.sv
// Bench for uart_ice40_cfg: three configurations, loopback and bench-driven serial frames.
module tb_uart_ice40_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [2:0] divc = 3'd0;
    always @(posedge clk) divc <= divc + 3'd1;
    wire ce_div = (divc == 3'd7);

    logic force_ce_a = 1'b0;
    logic glitch_a   = 1'b0;
    logic rxpin_c    = 1'b1;
    wire  ce_a = ce_div | force_ce_a;
    wire  txpin_a, txpin_b, txpin_c;
    wire  rxpin_a = txpin_a & ~glitch_a;
    wire  rxpin_b = txpin_b;

    uart_ice40_cfg_if #(.DATABITS(8)) if_a();
    uart_ice40_cfg_if #(.DATABITS(7)) if_b();
    uart_ice40_cfg_if #(.DATABITS(8)) if_c();

    uart_ice40_cfg #(.DATABITS(8)) dut_a (
        .clk(clk), .rst(rst), .bitxce(ce_a), .txpin(txpin_a), .rxpin(rxpin_a), .host(if_a));
    uart_ice40_cfg #(.DATABITS(7), .PARITY(2), .STOPBITS(2)) dut_b (
        .clk(clk), .rst(rst), .bitxce(ce_div), .txpin(txpin_b), .rxpin(rxpin_b), .host(if_b));
    uart_ice40_cfg #(.DATABITS(8), .PARITY(1), .SUBDIV16(1), .ADJUSTSAMPLEPOINT(1)) dut_c (
        .clk(clk), .rst(rst), .bitxce(1'b1), .txpin(txpin_c), .rxpin(rxpin_c), .host(if_c));

    int n_checks = 0;
    int n_fail   = 0;

    int rcv_a = 0, rcv_b = 0, rcv_c = 0, bt_a = 0, bt_b = 0;
    logic [7:0] lq_a = '0, lq_c = '0;
    logic [6:0] lq_b = '0;
    logic lpe_a = 0, lfe_a = 0, lpe_b = 0, lfe_b = 0, lpe_c = 0, lfe_c = 0;

    always @(negedge clk) begin
        if (if_a.bytercvd) begin rcv_a <= rcv_a + 1; lq_a <= if_a.q; lpe_a <= if_a.parerr; lfe_a <= if_a.framerr; end
        if (if_b.bytercvd) begin rcv_b <= rcv_b + 1; lq_b <= if_b.q; lpe_b <= if_b.parerr; lfe_b <= if_b.framerr; end
        if (if_c.bytercvd) begin rcv_c <= rcv_c + 1; lq_c <= if_c.q; lpe_c <= if_c.parerr; lfe_c <= if_c.framerr; end
        if (if_a.txbusy && ce_a)   bt_a <= bt_a + 1;
        if (if_b.txbusy && ce_div) bt_b <= bt_b + 1;
    end

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_par(input logic [7:0] w);
        return (($countones(w) % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic wait_rcv(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if ((which == 0 && rcv_a >= target) || (which == 1 && rcv_b >= target) ||
                (which == 2 && rcv_c >= target)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 2000 && if_a.txbusy; i++) @(negedge clk);
        @(posedge clk);
    endtask

    task automatic load_a(input logic [7:0] w);
        for (int i = 0; i < 2000 && if_a.txbusy; i++) @(negedge clk);
        @(negedge clk);
        if_a.d = w; if_a.load = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
    endtask

    task automatic load_b(input logic [6:0] w);
        for (int i = 0; i < 2000 && if_b.txbusy; i++) @(negedge clk);
        @(negedge clk);
        if_b.d = w; if_b.load = 1'b1;
        @(negedge clk);
        if_b.load = 1'b0;
    endtask

    // Serial frame into C: start, 8 data LSB first, parity, stop, one idle bit.
    // p100 is the bit period in hundredths of a clock.
    task automatic send_c(input logic [7:0] w, input bit flip, input int p100);
        logic [11:0] bits;
        int nclk;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = w[i];
        bits[9]  = odd_par(w) ^ flip;
        bits[10] = 1'b1;
        bits[11] = 1'b1;
        nclk = (12 * p100) / 100;
        for (int t = 0; t < nclk; t++) begin
            @(negedge clk);
            rxpin_c = bits[(t * 100) / p100];
        end
        rxpin_c = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (txpin_a !== 1'b1)       begin n_fail++; $display("FAIL reset_txpin_a: got %b want 1", txpin_a); end
        n_checks++; if (if_a.txbusy !== 1'b0)   begin n_fail++; $display("FAIL reset_txbusy_a: got %b want 0", if_a.txbusy); end
        n_checks++; if (if_a.bytercvd !== 1'b0) begin n_fail++; $display("FAIL reset_bytercvd_a: got %b want 0", if_a.bytercvd); end
        n_checks++; if (if_a.q !== 8'h00)       begin n_fail++; $display("FAIL reset_q_a: got %h want 00", if_a.q); end
        n_checks++; if (if_a.rxst !== 2'b00)    begin n_fail++; $display("FAIL reset_rxst_a: got %b want 00", if_a.rxst); end
        n_checks++; if (if_a.parerr !== 1'b0)   begin n_fail++; $display("FAIL reset_parerr_a: got %b want 0", if_a.parerr); end
        n_checks++; if (if_a.framerr !== 1'b0)  begin n_fail++; $display("FAIL reset_framerr_a: got %b want 0", if_a.framerr); end
        n_checks++; if (txpin_b !== 1'b1)       begin n_fail++; $display("FAIL reset_txpin_b: got %b want 1", txpin_b); end
        n_checks++; if (if_b.q !== 7'h00)       begin n_fail++; $display("FAIL reset_q_b: got %h want 00", if_b.q); end
        n_checks++; if (if_c.rxst !== 2'b00)    begin n_fail++; $display("FAIL reset_rxst_c: got %b want 00", if_c.rxst); end
    endtask

    task automatic test_8n1();
        bit ok;
        int old, bt0;
        logic [7:0] w;
        old = rcv_a; bt0 = bt_a;
        load_a(8'hC1);
        wait_rcv(0, old + 1, 1000, ok);
        wait_idle_a();
        n_checks++; if (!ok)              begin n_fail++; $display("FAIL 8n1_timeout: got no bytercvd want one"); end
        n_checks++; if (rcv_a !== old + 1) begin n_fail++; $display("FAIL 8n1_count: got %0d want %0d", rcv_a - old, 1); end
        n_checks++; if (lq_a !== 8'hC1)   begin n_fail++; $display("FAIL 8n1_q: got %h want c1", lq_a); end
        n_checks++; if (lpe_a !== 1'b0)   begin n_fail++; $display("FAIL 8n1_parerr: got %b want 0", lpe_a); end
        n_checks++; if (lfe_a !== 1'b0)   begin n_fail++; $display("FAIL 8n1_framerr: got %b want 0", lfe_a); end
        n_checks++; if (bt_a - bt0 !== 80) begin n_fail++; $display("FAIL 8n1_busy_ticks: got %0d want 80", bt_a - bt0); end
        for (int k = 0; k < 5; k++) begin
            w = 8'($urandom_range(0, 255));
            old = rcv_a;
            load_a(w);
            wait_rcv(0, old + 1, 1000, ok);
            n_checks++; if (!ok || lq_a !== w || lfe_a !== 1'b0)
                begin n_fail++; $display("FAIL 8n1_rand_q: got %h fe=%b ok=%b want %h fe=0", lq_a, lfe_a, ok, w); end
            wait_idle_a();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int old, bt0;
        logic [6:0] w;
        old = rcv_b;
        load_b(7'h4E);
        for (int i = 0; i < 2000 && if_b.txbusy; i++) @(negedge clk);
        if_b.d = 7'h4E; if_b.load = 1'b1;
        @(negedge clk);
        if_b.load = 1'b0;
        n_checks++; if (if_b.txbusy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got txbusy %b want 1", if_b.txbusy); end
        n_checks++; if (txpin_b !== 1'b0)     begin n_fail++; $display("FAIL b2b_start_follows: got txpin %b want 0", txpin_b); end
        @(posedge clk);
        n_checks++; if (rcv_b !== old + 1 || lq_b !== 7'h4E || lpe_b !== 1'b0)
            begin n_fail++; $display("FAIL b2b_first: got n=%0d q=%h pe=%b want n=1 q=4e pe=0", rcv_b - old, lq_b, lpe_b); end
        wait_rcv(1, old + 2, 1500, ok);
        n_checks++; if (!ok || lq_b !== 7'h4E || lpe_b !== 1'b0 || lfe_b !== 1'b0)
            begin n_fail++; $display("FAIL b2b_second: got ok=%b q=%h pe=%b fe=%b want q=4e pe=0 fe=0", ok, lq_b, lpe_b, lfe_b); end
        for (int i = 0; i < 2000 && if_b.txbusy; i++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            w = 7'($urandom_range(0, 127));
            old = rcv_b; bt0 = bt_b;
            load_b(w);
            wait_rcv(1, old + 1, 1500, ok);
            for (int i = 0; i < 2000 && if_b.txbusy; i++) @(negedge clk);
            @(posedge clk);
            n_checks++; if (!ok || lq_b !== w || lpe_b !== 1'b0 || lfe_b !== 1'b0)
                begin n_fail++; $display("FAIL 7e2_rand: got ok=%b q=%h pe=%b fe=%b want q=%h pe=0 fe=0", ok, lq_b, lpe_b, lfe_b, w); end
            n_checks++; if (bt_b - bt0 !== 88) begin n_fail++; $display("FAIL 7e2_busy_ticks: got %0d want 88", bt_b - bt0); end
        end
    endtask

    task automatic test_glitch();
        bit ok, saw1, saw_bad;
        int old;
        logic [7:0] w;
        old = rcv_a; saw1 = 0; saw_bad = 0;
        force_ce_a = 1'b1;
        @(negedge clk);
        glitch_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) glitch_a = 1'b0;
            if (if_a.rxst == 2'b01) saw1 = 1'b1;
            if (if_a.rxst[1])       saw_bad = 1'b1;
        end
        force_ce_a = 1'b0;
        @(posedge clk);
        n_checks++; if (saw1 !== 1'b1 || saw_bad !== 1'b0)
            begin n_fail++; $display("FAIL glitch_rxst_seq: got saw01=%b sawdata=%b want 1 0", saw1, saw_bad); end
        n_checks++; if (if_a.rxst !== 2'b00) begin n_fail++; $display("FAIL glitch_rxst_end: got %b want 00", if_a.rxst); end
        n_checks++; if (rcv_a !== old) begin n_fail++; $display("FAIL glitch_no_rcv: got %0d want 0", rcv_a - old); end
        load_a(8'hFF);
        repeat (3 * 64 + 32) @(negedge clk);
        glitch_a = 1'b1;
        repeat (64) @(negedge clk);
        glitch_a = 1'b0;
        wait_rcv(0, old + 1, 1500, ok);
        n_checks++; if (!ok || (lq_a === 8'hFF && lfe_a === 1'b0))
            begin n_fail++; $display("FAIL glitch_frame_hit: got ok=%b q=%h fe=%b want corrupt q or fe=1", ok, lq_a, lfe_a); end
        wait_idle_a();
        w = 8'($urandom_range(0, 255));
        old = rcv_a;
        load_a(w);
        wait_rcv(0, old + 1, 1000, ok);
        n_checks++; if (!ok || lq_a !== w || lfe_a !== 1'b0)
            begin n_fail++; $display("FAIL glitch_next_frame: got q=%h fe=%b want %h fe=0", lq_a, lfe_a, w); end
        wait_idle_a();
    endtask

    task automatic test_parity_break();
        bit ok;
        int old;
        logic [7:0] w;
        logic [1:0] st;
        w = 8'($urandom_range(0, 255));
        old = rcv_c;
        send_c(w, 1'b1, 1600);
        wait_rcv(2, old + 1, 100, ok);
        n_checks++; if (!ok || lq_c !== w || lpe_c !== 1'b1 || lfe_c !== 1'b0)
            begin n_fail++; $display("FAIL parity_flip: got ok=%b q=%h pe=%b fe=%b want q=%h pe=1 fe=0", ok, lq_c, lpe_c, lfe_c, w); end
        w = 8'($urandom_range(0, 255));
        old = rcv_c;
        send_c(w, 1'b0, 1600);
        wait_rcv(2, old + 1, 100, ok);
        n_checks++; if (!ok || lq_c !== w || lpe_c !== 1'b0)
            begin n_fail++; $display("FAIL parity_good: got ok=%b q=%h pe=%b want q=%h pe=0", ok, lq_c, lpe_c, w); end
        old = rcv_c;
        @(negedge clk);
        rxpin_c = 1'b0;
        repeat (2 * 11 * 16) @(negedge clk);
        st = if_c.rxst;
        @(posedge clk);
        n_checks++; if (st !== 2'b11) begin n_fail++; $display("FAIL break_rxst_hold: got %b want 11", st); end
        n_checks++; if (rcv_c !== old + 1 || lfe_c !== 1'b1 || lq_c !== 8'h00)
            begin n_fail++; $display("FAIL break_framerr: got n=%0d fe=%b q=%h want n=1 fe=1 q=00", rcv_c - old, lfe_c, lq_c); end
        @(negedge clk);
        rxpin_c = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (if_c.rxst !== 2'b00) begin n_fail++; $display("FAIL break_release: got %b want 00", if_c.rxst); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int old;
        load_a(8'($urandom_range(0, 255)));
        old = rcv_a;
        for (int i = 0; i < 500 && if_a.rxst != 2'b10; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (txpin_a !== 1'b1 || if_a.txbusy !== 1'b0 || if_a.rxst !== 2'b00)
            begin n_fail++; $display("FAIL midreset_state: got txpin=%b txbusy=%b rxst=%b want 1 0 00", txpin_a, if_a.txbusy, if_a.rxst); end
        repeat (800) @(negedge clk);
        @(posedge clk);
        n_checks++; if (rcv_a !== old) begin n_fail++; $display("FAIL midreset_lost: got %0d rcv want 0", rcv_a - old); end
        load_a(8'h55);
        wait_rcv(0, old + 1, 1000, ok);
        n_checks++; if (!ok || lq_a !== 8'h55 || lfe_a !== 1'b0)
            begin n_fail++; $display("FAIL midreset_next: got ok=%b q=%h fe=%b want q=55 fe=0", ok, lq_a, lfe_a); end
        wait_idle_a();
    endtask

    task automatic test_baud_sweep();
        bit ok;
        int old;
        int pcts[3] = '{97, 100, 103};
        logic [7:0] w;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                w = 8'($urandom_range(0, 255));
                old = rcv_c;
                send_c(w, 1'b0, 16 * pcts[p]);
                wait_rcv(2, old + 1, 100, ok);
                n_checks++; if (!ok || lq_c !== w || lpe_c !== 1'b0 || lfe_c !== 1'b0)
                    begin n_fail++; $display("FAIL sweep_%0d: got ok=%b q=%h pe=%b fe=%b want q=%h pe=0 fe=0", pcts[p], ok, lq_c, lpe_c, lfe_c, w); end
            end
        end
    endtask

    initial begin
        if_a.load = 1'b0; if_a.d = '0;
        if_b.load = 1'b0; if_b.d = '0;
        if_c.load = 1'b0; if_c.d = '0;
        test_reset();
        test_8n1();
        test_back_to_back();
        test_glitch();
        test_parity_break();
        test_reset_midframe();
        test_baud_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
